// File: rtl/output4to1.sv
// Router output port stage: round-robin merge of four four-phase req/ack
// input channels onto one outgoing link, with synchronised req/ack inputs.
module output4to1 #(
   parameter int unsigned n           = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   ins_req,
   output logic [3:0]   ins_ack,
   input  logic [n-1:0] ins_data [4],
   output logic         out_req,
   input  logic         out_ack,
   output logic [n-1:0] out_data,
   output logic [1:0]   grant,
   output logic         busy,
   output logic [15:0]  pkt_count
);

   typedef enum logic [2:0] {StIdle, StOutReq, StOutRel, StInAck, StInRel} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] req_sync_q [4];
   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic [3:0]             sreq;
   logic                   sack;

   logic [1:0]   ptr_q, ptr_d;
   logic [1:0]   grant_q, grant_d;
   logic         busy_q, busy_d;
   logic         out_req_q, out_req_d;
   logic [3:0]   ins_ack_q, ins_ack_d;
   logic [n-1:0] out_data_q, out_data_d;
   logic [15:0]  pkt_count_q, pkt_count_d;

   logic         win_found;
   logic [1:0]   win_idx;
   logic [1:0]   cand;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 4; k++) req_sync_q[k] <= '0;
         ack_sync_q <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            req_sync_q[k] <= {req_sync_q[k][SYNC_STAGES-2:0], ins_req[k]};
         end
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], out_ack};
      end
   end

   always_comb begin
      for (int k = 0; k < 4; k++) sreq[k] = req_sync_q[k][SYNC_STAGES-1];
      sack = ack_sync_q[SYNC_STAGES-1];
   end

   // First pending channel in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = ptr_q;
      for (int i = 0; i < 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!win_found && sreq[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      busy_d      = busy_q;
      out_req_d   = out_req_q;
      ins_ack_d   = ins_ack_q;
      out_data_d  = out_data_q;
      pkt_count_d = pkt_count_q;
      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               grant_d    = win_idx;
               out_data_d = ins_data[win_idx];
               busy_d     = 1'b1;
               out_req_d  = 1'b1;
               state_d    = StOutReq;
            end
         end
         StOutReq: begin
            if (sack) begin
               out_req_d = 1'b0;
               state_d   = StOutRel;
            end
         end
         StOutRel: begin
            if (!sack) begin
               ins_ack_d[grant_q] = 1'b1;
               state_d            = StInAck;
            end
         end
         StInAck: begin
            if (!sreq[grant_q]) begin
               ins_ack_d = '0;
               state_d   = StInRel;
            end
         end
         StInRel: begin
            ptr_d       = grant_q + 2'd1;
            pkt_count_d = pkt_count_q + 16'd1;
            busy_d      = 1'b0;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         grant_q     <= '0;
         busy_q      <= 1'b0;
         out_req_q   <= 1'b0;
         ins_ack_q   <= '0;
         out_data_q  <= '0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         out_req_q   <= out_req_d;
         ins_ack_q   <= ins_ack_d;
         out_data_q  <= out_data_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   assign out_req   = out_req_q;
   assign ins_ack   = ins_ack_q;
   assign out_data  = out_data_q;
   assign grant     = grant_q;
   assign busy      = busy_q;
   assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_output4to1.sv
// Directed bench for output4to1: reset, latency, round-robin order,
// fairness, counter wrap and reset during a transfer.
module tb_output4to1;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ins_req;
   logic [3:0]  ins_ack;
   logic [31:0] ins_data [4];
   logic        out_req;
   logic        out_ack;
   logic [31:0] out_data;
   logic [1:0]  grant;
   logic        busy;
   logic [15:0] pkt_count;

   int errors = 0;
   int checks = 0;

   output4to1 #(.n(32), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .ins_req  (ins_req),
      .ins_ack  (ins_ack),
      .ins_data (ins_data),
      .out_req  (out_req),
      .out_ack  (out_ack),
      .out_data (out_data),
      .grant    (grant),
      .busy     (busy),
      .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_out_req(input logic v, input string tag);
      for (int i = 0; i < 40; i++) begin
         if (out_req === v) break;
         tick();
      end
      chk(tag, {31'd0, out_req}, {31'd0, v});
   endtask

   task automatic wait_ack(input int ch, input logic v, input string tag);
      for (int i = 0; i < 40; i++) begin
         if (ins_ack[ch] === v) break;
         tick();
      end
      chk(tag, {31'd0, ins_ack[ch]}, {31'd0, v});
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (busy === 1'b0) break;
         tick();
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   // One full handshake with an instant downstream and upstream partner.
   task automatic do_xfer(input int ch, input logic [31:0] data, input logic [15:0] cnt);
      logic [3:0] onehot;
      onehot = 4'b0001 << ch;
      wait_out_req(1'b1, "out_req_rise");
      chk("grant", {30'd0, grant}, ch);
      chk("out_data", out_data, data);
      chk("busy_set", {31'd0, busy}, 32'd1);
      tick();
      out_ack = 1'b1;
      wait_out_req(1'b0, "out_req_fall");
      chk("ack_before_sack_fall", {28'd0, ins_ack}, 32'd0);
      out_ack = 1'b0;
      wait_ack(ch, 1'b1, "in_ack_rise");
      chk("ack_onehot", {28'd0, ins_ack}, {28'd0, onehot});
      chk("out_data_held", out_data, data);
      ins_req[ch] = 1'b0;
      wait_ack(ch, 1'b0, "in_ack_fall");
      wait_idle("busy_clear");
      chk("pkt_count", {16'd0, pkt_count}, {16'd0, cnt});
   endtask

   initial begin
      // Reset held with random inputs
      rst     = 1'b0;
      ins_req = 4'($urandom);
      out_ack = 1'($urandom);
      for (int k = 0; k < 4; k++) ins_data[k] = $urandom;
      repeat (4) tick();
      chk("rst_out_req", {31'd0, out_req}, 32'd0);
      chk("rst_ins_ack", {28'd0, ins_ack}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_grant", {30'd0, grant}, 32'd0);
      ins_req = 4'd0;
      out_ack = 1'b0;
      for (int k = 0; k < 4; k++) ins_data[k] = 32'd0;
      tick();
      rst = 1'b1;
      repeat (4) tick();

      // Single transfer on ch2, out_req rises on the third edge
      ins_data[2] = 32'hCAFE0002;
      ins_req[2]  = 1'b1;
      tick();
      chk("lat_e0", {31'd0, out_req}, 32'd0);
      tick();
      chk("lat_e1", {31'd0, out_req}, 32'd0);
      tick();
      chk("lat_e2", {31'd0, out_req}, 32'd1);
      do_xfer(2, 32'hCAFE0002, 16'd1);

      // Pointer now 3: ch3 beats ch0, then pointer wraps to 0
      ins_data[0] = 32'h0000B000;
      ins_data[3] = 32'h0000B003;
      ins_req     = 4'b1001;
      do_xfer(3, 32'h0000B003, 16'd2);
      do_xfer(0, 32'h0000B000, 16'd3);

      // Contention from reset: strict order 0,1,2,3
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) ins_data[k] = 32'hA0 + k;
      ins_req = 4'b1111;
      do_xfer(0, 32'hA0, 16'd1);
      do_xfer(1, 32'hA1, 16'd2);
      do_xfer(2, 32'hA2, 16'd3);
      do_xfer(3, 32'hA3, 16'd4);

      // Fairness: ch1 re-requests at once, ch3 waits and is never skipped
      ins_data[1] = 32'h11;
      ins_data[3] = 32'h33;
      ins_req     = 4'b1010;
      do_xfer(1, 32'h11, 16'd5);
      ins_data[1] = 32'h12;
      ins_req[1]  = 1'b1;
      do_xfer(3, 32'h33, 16'd6);
      ins_data[3] = 32'h34;
      ins_req[3]  = 1'b1;
      do_xfer(1, 32'h12, 16'd7);
      do_xfer(3, 32'h34, 16'd8);

      // Counter wrap 0xFFFF -> 0x0000
      @(negedge clk);
      force dut.pkt_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.pkt_count_q;
      tick();
      chk("preload", {16'd0, pkt_count}, 32'h0000FFFF);
      ins_data[2] = 32'h22;
      ins_req[2]  = 1'b1;
      do_xfer(2, 32'h22, 16'h0000);

      // Reset while ch0 sits in the input-ack phase
      rst = 1'b0;
      tick();
      rst = 1'b1;
      ins_data[0] = 32'h00C0FFEE;
      ins_req[0]  = 1'b1;
      wait_out_req(1'b1, "mid_out_req_rise");
      tick();
      out_ack = 1'b1;
      wait_out_req(1'b0, "mid_out_req_fall");
      out_ack = 1'b0;
      wait_ack(0, 1'b1, "mid_in_ack_rise");
      #2;
      rst = 1'b0;
      #1;
      chk("mid_ack_drop", {28'd0, ins_ack}, 32'd0);
      chk("mid_out_req_drop", {31'd0, out_req}, 32'd0);
      chk("mid_pkt_count", {16'd0, pkt_count}, 32'd0);
      chk("mid_busy_drop", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      do_xfer(0, 32'h00C0FFEE, 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/output4to1.md
# output4to1

Synchronous output port stage for the router: merges the four per-direction request channels produced by the input ports' 4-way demultiplexers into one outgoing router link. It arbitrates round-robin among pending inputs, captures the winning flit into an output register, and completes a four-phase req/ack handshake on both sides. Incoming req and ack signals arrive from asynchronous neighbours and are synchronised internally.

## Interface
Parameters:
- n, 32, flit width in bits (data field of RTPort)
- SYNC_STAGES, 2, flip-flop depth of each req/ack synchroniser (≥2)

Ports:
- clk  input  1  single block clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- ins[4]  RTPort.Input  —  four input channels; per channel: req in 1, ack out 1, data in n
- out  RTPort.Output  —  output link: req out 1, ack in 1, data out n
- grant  output  2  index of channel currently being served (valid when busy=1)
- busy  output  1  high from grant until upstream release completes
- pkt_count  output  16  count of completed transfers, wraps 0xFFFF→0x0000

## Operation
- Handshake on every channel is four-phase return-to-zero, bundled data: data stable before req rises and held until ack rises.
- ins[k].req and out.ack each pass through a SYNC_STAGES synchroniser; FSM sees only synchronised values (sreq[k], sack).
- Round-robin pointer p (2 bits): search order p, p+1, p+2, p+3 mod 4; first channel with sreq=1 wins. On completion p ← g+1 mod 4.
- FSM states:
  - IDLE: if any sreq=1, g ← winner, out.data ← ins[g].data, busy←1 → OUT_REQ; else stay.
  - OUT_REQ: out.req=1; on sack=1 → OUT_REL.
  - OUT_REL: out.req=0; on sack=0 → IN_ACK.
  - IN_ACK: ins[g].ack=1; on sreq[g]=0 → IN_REL.
  - IN_REL: ins[g].ack=0, p ← g+1, pkt_count += 1, busy←0 → IDLE.
- Only ins[g].ack is ever driven high; the other three acks stay 0.
- Requests arriving on other channels while busy are held pending (upstream keeps req high) and are served in later rounds.
- out.data register changes only on IDLE→OUT_REQ; held through the whole transfer.
- pkt_count is 16-bit unsigned, modulo 2^16.

## Timing
- All outputs registered. Reset (rst=0, asynchronous): state IDLE, p=0, out.req=0, out.data=0, all ins[k].ack=0, grant=0, busy=0, pkt_count=0, all synchroniser flops 0.
- Reset mid-transfer: outputs drop to reset values immediately; partial transfer is abandoned, not counted.
- Latency (SYNC_STAGES=2): ins[k].req set before edge E0 → sreq high after E1 → out.req and out.data valid after E2 (SYNC_STAGES+1 edges).
- Each subsequent phase (sack rise, sack fall, sreq fall) likewise takes SYNC_STAGES+1 edges from the external transition to the registered response.
- Minimum full cycle with instant-responding neighbours: 4×(SYNC_STAGES+1)+1 = 13 edges per flit at SYNC_STAGES=2.
- Simultaneous requests on several channels in the same cycle: strictly pointer order; no channel waits more than 3 other transfers.
- Upstream req falling before ack (protocol violation) in OUT_REQ/OUT_REL: ignored; data already captured.
- Deassertion of rst is released synchronously to clk by the integrator; block itself does not synchronise rst.

## Test plan
- Reset: hold rst=0 with random inputs → out.req=0, all acks=0, out.data=0, pkt_count=0, busy=0.
- Single transfer: ins[2].req=1, data=0xCAFE0002, downstream acks after 1 cycle → out.data=0xCAFE0002, out.req high 3 edges after req, ins[2].ack raised only after out.ack fall seen, pkt_count=1, p=3.
- Contention: all four reqs high at once from reset → served in order 0,1,2,3 with distinct data 0xA0..0xA3 appearing on out.data; pkt_count=4.
- Fairness: ch1 re-requests immediately after each completion while ch3 waits → sequence alternates 1,3,1,3; ch3 never skipped.
- Wrap: preload via 65536 transfers (or force) → pkt_count goes 0xFFFF→0x0000; pointer wraps 3→0.
- Reset mid-operation: assert rst=0 while in IN_ACK on ch0 → ins[0].ack and out.req drop asynchronously, pkt_count unchanged, after release ch0's still-high req is re-served from IDLE.
